// File: rtl/otter_mem2_arbiter.sv
// Arbiter for OTTER memory port 2: CPU (A) vs programmer/debug master (B).
// B has fixed priority with a starvation limit; B can lock A out; read data is routed back to its owner.
module otter_mem2_arbiter #(
   parameter int MAX_B_BURST = 4,
   parameter int AW          = 32
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          A_REQ,
   input  logic          A_WE,
   input  logic [AW-1:0] A_ADDR,
   input  logic [31:0]   A_WDATA,
   input  logic [1:0]    A_SIZE,
   input  logic          A_SIGN,
   output logic          A_GNT,
   output logic          A_RVALID,
   output logic [31:0]   A_RDATA,
   input  logic          B_REQ,
   input  logic          B_WE,
   input  logic [AW-1:0] B_ADDR,
   input  logic [31:0]   B_WDATA,
   input  logic [1:0]    B_SIZE,
   input  logic          B_SIGN,
   output logic          B_GNT,
   output logic          B_RVALID,
   output logic [31:0]   B_RDATA,
   input  logic          B_LOCK,
   output logic          LOCKED,
   output logic          MEM_READ2,
   output logic          MEM_WRITE2,
   output logic [AW-1:0] MEM_ADDR2,
   output logic [31:0]   MEM_DIN2,
   output logic [1:0]    MEM_SIZE,
   output logic          MEM_SIGN,
   input  logic [31:0]   MEM_DOUT2
);

   localparam logic [1:0] ST_ARB    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_A     = 2'd1;
   localparam logic [1:0] OWN_B     = 2'd2;

   localparam logic [3:0] LP_MAX_BURST = 4'(MAX_B_BURST);

   logic [1:0] r_state, w_state_nxt;
   logic [1:0] r_rd_owner, w_rd_owner_nxt;
   logic [3:0] r_streak, w_streak_nxt;
   logic       w_a_allowed;
   logic       w_a_gnt;
   logic       w_b_gnt;

   // A is only eligible in ARB, and never in the cycle B_LOCK is asserted.
   assign w_a_allowed = (r_state == ST_ARB) && !B_LOCK;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
      if (B_REQ && A_REQ && w_a_allowed) begin
         if (r_streak < LP_MAX_BURST) w_b_gnt = 1'b1;
         else                         w_a_gnt = 1'b1;
      end else if (B_REQ) begin
         w_b_gnt = 1'b1;
      end else if (A_REQ && w_a_allowed) begin
         w_a_gnt = 1'b1;
      end
   end

   always_comb begin
      w_streak_nxt = r_streak;
      if (r_state == ST_LOCKED || w_a_gnt || !A_REQ)
         w_streak_nxt = 4'd0;
      else if (w_b_gnt && r_streak < LP_MAX_BURST)
         w_streak_nxt = r_streak + 4'd1;
   end

   always_comb begin
      w_rd_owner_nxt = OWN_NONE;
      if (w_a_gnt && !A_WE)      w_rd_owner_nxt = OWN_A;
      else if (w_b_gnt && !B_WE) w_rd_owner_nxt = OWN_B;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARB:
            if (B_LOCK) w_state_nxt = (r_rd_owner == OWN_A) ? ST_DRAIN : ST_LOCKED;
         ST_DRAIN:
            if (!B_LOCK)                   w_state_nxt = ST_ARB;
            else if (r_rd_owner != OWN_A)  w_state_nxt = ST_LOCKED;
         ST_LOCKED:
            if (!B_LOCK) w_state_nxt = ST_ARB;
         default:
            w_state_nxt = ST_ARB;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= ST_ARB;
         r_rd_owner <= OWN_NONE;
         r_streak   <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_owner <= w_rd_owner_nxt;
         r_streak   <= w_streak_nxt;
      end
   end

   // Grants are combinational, so they are also masked while reset is held.
   assign A_GNT = w_a_gnt && RST_N;
   assign B_GNT = w_b_gnt && RST_N;

   always_comb begin
      MEM_READ2  = 1'b0;
      MEM_WRITE2 = 1'b0;
      MEM_ADDR2  = '0;
      MEM_DIN2   = 32'd0;
      MEM_SIZE   = 2'd0;
      MEM_SIGN   = 1'b0;
      if (A_GNT) begin
         MEM_READ2  = !A_WE;
         MEM_WRITE2 = A_WE;
         MEM_ADDR2  = A_ADDR;
         MEM_DIN2   = A_WDATA;
         MEM_SIZE   = A_SIZE;
         MEM_SIGN   = A_SIGN;
      end else if (B_GNT) begin
         MEM_READ2  = !B_WE;
         MEM_WRITE2 = B_WE;
         MEM_ADDR2  = B_ADDR;
         MEM_DIN2   = B_WDATA;
         MEM_SIZE   = B_SIZE;
         MEM_SIGN   = B_SIGN;
      end
   end

   assign A_RVALID = (r_rd_owner == OWN_A);
   assign B_RVALID = (r_rd_owner == OWN_B);
   assign A_RDATA  = A_RVALID ? MEM_DOUT2 : 32'd0;
   assign B_RDATA  = B_RVALID ? MEM_DOUT2 : 32'd0;

   // Lock is reported in DRAIN as soon as no A read is still outstanding.
   assign LOCKED = (r_state == ST_LOCKED) ||
                   ((r_state == ST_DRAIN) && (r_rd_owner != OWN_A));

endmodule

// File: tb/tb_otter_mem2_arbiter.sv
// Directed bench for otter_mem2_arbiter: inputs driven on the falling edge, outputs sampled 1 ns later.
module tb_otter_mem2_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        A_REQ, A_WE, A_SIGN, A_GNT, A_RVALID;
   logic [31:0] A_ADDR, A_WDATA, A_RDATA;
   logic [1:0]  A_SIZE;
   logic        B_REQ, B_WE, B_SIGN, B_GNT, B_RVALID;
   logic [31:0] B_ADDR, B_WDATA, B_RDATA;
   logic [1:0]  B_SIZE;
   logic        B_LOCK, LOCKED;
   logic        MEM_READ2, MEM_WRITE2, MEM_SIGN;
   logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
   logic [1:0]  MEM_SIZE;

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   otter_mem2_arbiter #(.MAX_B_BURST(4), .AW(32)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_SIZE(A_SIZE),
      .A_SIGN(A_SIGN), .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
      .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_SIZE(B_SIZE),
      .B_SIGN(B_SIGN), .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
      .B_LOCK(B_LOCK), .LOCKED(LOCKED),
      .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2), .MEM_ADDR2(MEM_ADDR2),
      .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
   );

   task automatic clear_inputs();
      A_REQ = 0; A_WE = 0; A_ADDR = 0; A_WDATA = 0; A_SIZE = 0; A_SIGN = 0;
      B_REQ = 0; B_WE = 0; B_ADDR = 0; B_WDATA = 0; B_SIZE = 0; B_SIGN = 0;
      B_LOCK = 0; MEM_DOUT2 = 0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      A_REQ = 1; B_REQ = 1; B_WE = 1; B_ADDR = 32'h44; MEM_DOUT2 = 32'h5555_AAAA;
      #1;
      n_total++;
      if ({A_GNT, B_GNT, MEM_READ2, MEM_WRITE2, A_RVALID, B_RVALID, LOCKED, MEM_SIGN, MEM_SIZE} !== 10'd0)
         $display("FAIL reset_ctrl: got %b want 0", {A_GNT, B_GNT, MEM_READ2, MEM_WRITE2, A_RVALID, B_RVALID, LOCKED, MEM_SIGN, MEM_SIZE});
      else n_pass++;
      n_total++;
      if ({MEM_ADDR2, MEM_DIN2, A_RDATA, B_RDATA} !== 128'd0)
         $display("FAIL reset_data: addr=%h din=%h ard=%h brd=%h want 0", MEM_ADDR2, MEM_DIN2, A_RDATA, B_RDATA);
      else n_pass++;
      clear_inputs();
      RST_N = 1;
   endtask

   task automatic test_a_read();
      @(negedge CLK);
      A_REQ = 1; A_WE = 0; A_ADDR = 32'h100; A_SIZE = 2;
      #1;
      n_total++;
      if ({A_GNT, B_GNT, MEM_READ2, MEM_WRITE2} !== 4'b1010 || MEM_ADDR2 !== 32'h100 || MEM_SIZE !== 2'd2)
         $display("FAIL a_read_grant: gnt/rd/wr=%b addr=%h size=%0d want 1010 100 2", {A_GNT, B_GNT, MEM_READ2, MEM_WRITE2}, MEM_ADDR2, MEM_SIZE);
      else n_pass++;
      @(negedge CLK);
      A_REQ = 0; MEM_DOUT2 = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if ({A_RVALID, B_RVALID, MEM_READ2} !== 3'b100 || A_RDATA !== 32'hDEAD_BEEF || B_RDATA !== 32'd0)
         $display("FAIL a_read_return: av/bv/rd=%b ardata=%h brdata=%h want 100 deadbeef 0", {A_RVALID, B_RVALID, MEM_READ2}, A_RDATA, B_RDATA);
      else n_pass++;
      @(negedge CLK);
      #1;
      n_total++;
      if ({A_RVALID, B_RVALID} !== 2'b00)
         $display("FAIL a_read_pulse: rvalid=%b want 00", {A_RVALID, B_RVALID});
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_b_write();
      @(negedge CLK);
      B_REQ = 1; B_WE = 1; B_ADDR = 32'h2000; B_WDATA = 32'h1234_5678; B_SIZE = 2; B_SIGN = 1;
      #1;
      n_total++;
      if ({B_GNT, A_GNT, MEM_WRITE2, MEM_READ2, MEM_SIGN} !== 5'b10101 || MEM_ADDR2 !== 32'h2000 ||
          MEM_DIN2 !== 32'h1234_5678 || MEM_SIZE !== 2'd2)
         $display("FAIL b_write: ctl=%b addr=%h din=%h size=%0d want 10101 2000 12345678 2",
                  {B_GNT, A_GNT, MEM_WRITE2, MEM_READ2, MEM_SIGN}, MEM_ADDR2, MEM_DIN2, MEM_SIZE);
      else n_pass++;
      @(negedge CLK);
      clear_inputs();
      #1;
      n_total++;
      if ({B_RVALID, A_RVALID, MEM_WRITE2} !== 3'b000)
         $display("FAIL b_write_no_rvalid: got %b want 000", {B_RVALID, A_RVALID, MEM_WRITE2});
      else n_pass++;
   endtask

   // Both requesters write continuously; A wins every fifth cycle.
   task automatic test_starvation();
      logic exp_b;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         A_REQ = 1; A_WE = 1; A_ADDR = 32'hA0; B_REQ = 1; B_WE = 1; B_ADDR = 32'hB0;
         #1;
         exp_b = (i % 5 != 4);
         n_total++;
         if ({A_GNT, B_GNT} !== {!exp_b, exp_b} || MEM_ADDR2 !== (exp_b ? 32'hB0 : 32'hA0))
            $display("FAIL starve_seq[%0d]: a/b=%b addr=%h want %b %h", i, {A_GNT, B_GNT}, MEM_ADDR2,
                     {!exp_b, exp_b}, exp_b ? 32'hB0 : 32'hA0);
         else n_pass++;
      end
      clear_inputs();
      @(negedge CLK);
   endtask

   // Dropping A_REQ for a cycle restarts the streak count.
   task automatic test_streak_clear();
      logic exp_b;
      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         A_REQ = (i != 3); A_WE = 1; A_ADDR = 32'hA4; B_REQ = 1; B_WE = 1; B_ADDR = 32'hB4;
         #1;
         exp_b = (i != 8);
         n_total++;
         if ({A_GNT, B_GNT} !== {!exp_b, exp_b})
            $display("FAIL streak_clear[%0d]: a/b=%b want %b", i, {A_GNT, B_GNT}, {!exp_b, exp_b});
         else n_pass++;
      end
      clear_inputs();
      @(negedge CLK);
   endtask

   task automatic test_lock();
      @(negedge CLK);
      A_REQ = 1; A_WE = 0; A_ADDR = 32'h300;
      #1;
      n_total++;
      if ({A_GNT, MEM_READ2} !== 2'b11) $display("FAIL lock_t0_agnt: got %b want 11", {A_GNT, MEM_READ2});
      else n_pass++;
      @(negedge CLK);
      A_ADDR = 32'h304; B_LOCK = 1; MEM_DOUT2 = 32'hCAFE_F00D;
      #1;
      n_total++;
      if ({A_GNT, A_RVALID, LOCKED, MEM_READ2} !== 4'b0100 || A_RDATA !== 32'hCAFE_F00D)
         $display("FAIL lock_t1: gnt/rv/lk/rd=%b rdata=%h want 0100 cafef00d", {A_GNT, A_RVALID, LOCKED, MEM_READ2}, A_RDATA);
      else n_pass++;
      @(negedge CLK);
      B_REQ = 1; B_WE = 0; B_ADDR = 32'h500; MEM_DOUT2 = 32'h0;
      #1;
      n_total++;
      if ({LOCKED, A_GNT, B_GNT, A_RVALID} !== 4'b1010 || MEM_ADDR2 !== 32'h500)
         $display("FAIL lock_t2: lk/ag/bg/av=%b addr=%h want 1010 500", {LOCKED, A_GNT, B_GNT, A_RVALID}, MEM_ADDR2);
      else n_pass++;
      @(negedge CLK);
      B_REQ = 0; MEM_DOUT2 = 32'h0BAD_F00D;
      #1;
      n_total++;
      if ({LOCKED, A_GNT, B_RVALID, A_RVALID} !== 4'b1010 || B_RDATA !== 32'h0BAD_F00D)
         $display("FAIL lock_t3: lk/ag/bv/av=%b brdata=%h want 1010 0badf00d", {LOCKED, A_GNT, B_RVALID, A_RVALID}, B_RDATA);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         n_total++;
         if ({LOCKED, A_GNT, MEM_READ2} !== 3'b100)
            $display("FAIL lock_hold[%0d]: lk/ag/rd=%b want 100", i, {LOCKED, A_GNT, MEM_READ2});
         else n_pass++;
      end
      @(negedge CLK);
      B_LOCK = 0;
      @(negedge CLK);
      #1;
      n_total++;
      if ({A_GNT, MEM_READ2, LOCKED} !== 3'b110 || MEM_ADDR2 !== 32'h304)
         $display("FAIL lock_release: ag/rd/lk=%b addr=%h want 110 304", {A_GNT, MEM_READ2, LOCKED}, MEM_ADDR2);
      else n_pass++;
      @(negedge CLK);
      A_REQ = 0; MEM_DOUT2 = 32'h7777_0304;
      #1;
      n_total++;
      if (A_RVALID !== 1'b1 || A_RDATA !== 32'h7777_0304)
         $display("FAIL lock_release_rdata: rv=%b rdata=%h want 1 77770304", A_RVALID, A_RDATA);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      B_REQ = 1; B_WE = 0; B_ADDR = 32'h400; A_REQ = 1; A_WE = 0; A_ADDR = 32'h404;
      #1;
      n_total++;
      if ({B_GNT, A_GNT, MEM_READ2} !== 3'b101) $display("FAIL rst_mid_grant: got %b want 101", {B_GNT, A_GNT, MEM_READ2});
      else n_pass++;
      @(posedge CLK);
      MEM_DOUT2 = 32'h1357_9BDF;
      #2 RST_N = 0;
      #1;
      n_total++;
      if ({B_RVALID, A_RVALID, B_GNT, A_GNT, MEM_READ2, MEM_WRITE2, LOCKED} !== 7'd0 ||
          B_RDATA !== 32'd0 || MEM_ADDR2 !== 32'd0)
         $display("FAIL rst_mid_async: ctl=%b brdata=%h addr=%h want 0", {B_RVALID, A_RVALID, B_GNT, A_GNT, MEM_READ2, MEM_WRITE2, LOCKED}, B_RDATA, MEM_ADDR2);
      else n_pass++;
      @(negedge CLK);
      clear_inputs();
      MEM_DOUT2 = 32'h1357_9BDF;
      @(negedge CLK);
      RST_N = 1;
      #1;
      n_total++;
      if ({B_RVALID, A_RVALID} !== 2'b00) $display("FAIL rst_mid_release: rvalid=%b want 00", {B_RVALID, A_RVALID});
      else n_pass++;
      @(negedge CLK);
      #1;
      n_total++;
      if ({B_RVALID, A_RVALID} !== 2'b00) $display("FAIL rst_mid_after: rvalid=%b want 00", {B_RVALID, A_RVALID});
      else n_pass++;
   endtask

   task automatic test_idle();
      clear_inputs();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         #1;
         n_total++;
         if ({MEM_READ2, MEM_WRITE2, A_GNT, B_GNT, dut.r_streak} !== 8'd0)
            $display("FAIL idle[%0d]: rd/wr/ag/bg=%b streak=%0d want 0000 0", i,
                     {MEM_READ2, MEM_WRITE2, A_GNT, B_GNT}, dut.r_streak);
         else n_pass++;
      end
   endtask

   initial begin
      RST_N = 0;
      clear_inputs();
      test_reset();
      test_a_read();
      test_b_write();
      test_starvation();
      test_streak_clear();
      test_lock();
      test_reset_mid();
      test_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
